// File: rtl/ddr2_rank_dispatcher.sv
// Multi-rank DDR2 command dispatcher: in-order command queue, per-rank issue, in-order read return.
// Optional per-rank stall counters are enabled with `define DDR2_RANK_STALL_CNT_EN.
module ddr2_rank_dispatcher #(
    parameter int unsigned  HOST_ADDR_WIDTH = 26,
    parameter int unsigned  ADDR_WIDTH      = 25,
    parameter int unsigned  RANK_BITS       = 1,
    parameter int unsigned  DATA_WIDTH      = 64,
    parameter int unsigned  CQ_DEPTH        = 8,
    parameter int unsigned  TAG_DEPTH       = 8,
    parameter logic [2:0]   CMD_READ        = 3'b001,
    localparam int unsigned NUM_RANKS       = 2 ** RANK_BITS
) (
    input  logic                            CLK,
    input  logic                            RESETBAR,
    input  logic [2:0]                      CMD,
    input  logic [1:0]                      SZ,
    input  logic [HOST_ADDR_WIDTH-1:0]      ADDR,
    input  logic                            cmd_put,
    input  logic [DATA_WIDTH-1:0]           DIN,
    input  logic                            put_dataFIFO,
    input  logic                            FETCHING,
    output logic [DATA_WIDTH-1:0]           DOUT,
    output logic [HOST_ADDR_WIDTH-1:0]      RADDR,
    output logic                            VALIDOUT,
    output logic                            NOTFULL,
    output logic                            READY,
    output logic [2:0]                      core_cmd,
    output logic [1:0]                      core_sz,
    output logic [ADDR_WIDTH-1:0]           core_addr,
    output logic [NUM_RANKS-1:0]            core_cmd_put,
    output logic [DATA_WIDTH-1:0]           core_din,
    output logic [NUM_RANKS-1:0]            core_put_data,
    output logic [NUM_RANKS-1:0]            core_fetching,
    input  logic [NUM_RANKS-1:0]            core_ready,
    input  logic [NUM_RANKS-1:0]            core_notfull,
    input  logic [NUM_RANKS-1:0]            core_validout,
    input  logic [NUM_RANKS*DATA_WIDTH-1:0] core_dout,
    input  logic [NUM_RANKS*ADDR_WIDTH-1:0] core_raddr
`ifdef DDR2_RANK_STALL_CNT_EN
    ,
    output logic [NUM_RANKS*16-1:0]         stall_cnt
`endif
);

    localparam int unsigned CQ_AW  = $clog2(CQ_DEPTH);
    localparam int unsigned TAG_AW = $clog2(TAG_DEPTH);

    typedef struct packed {
        logic [2:0]            cmd;
        logic [1:0]            sz;
        logic [RANK_BITS-1:0]  rank;
        logic [ADDR_WIDTH-1:0] addr;
    } cq_entry_t;

    typedef struct packed {
        logic [RANK_BITS-1:0] rank;
        logic [3:0]           beats;
    } tag_entry_t;

    // Command queue
    cq_entry_t          cq_mem [CQ_DEPTH];
    logic [CQ_AW-1:0]   cq_wr_ptr, cq_rd_ptr;
    logic [CQ_AW:0]     cq_cnt, cq_cnt_next;
    logic               notfull_q;
    cq_entry_t          cq_head;
    logic               cq_push, cq_empty, head_is_read, issue_c;

    // Outstanding read tags
    tag_entry_t         tag_mem [TAG_DEPTH];
    logic [TAG_AW-1:0]  tag_wr_ptr, tag_rd_ptr;
    logic [TAG_AW:0]    tag_cnt, tag_cnt_next;
    tag_entry_t         tag_head;
    logic               tag_full, tag_nonempty, tag_push, tag_pop, beat_fire;
    logic [3:0]         beat_cnt, beats_left;
    logic [RANK_BITS-1:0] head_rank;

    assign cq_push      = cmd_put && notfull_q;
    assign cq_empty     = (cq_cnt == '0);
    assign cq_head      = cq_mem[cq_rd_ptr];
    assign head_is_read = (cq_head.cmd == CMD_READ);
    assign issue_c      = !cq_empty && core_ready[cq_head.rank] && core_notfull[cq_head.rank]
                          && (!head_is_read || !tag_full);
    assign NOTFULL      = notfull_q;

    always_comb begin
        cq_cnt_next = cq_cnt;
        case ({cq_push, issue_c})
            2'b10:   cq_cnt_next = cq_cnt + (CQ_AW+1)'(1);
            2'b01:   cq_cnt_next = cq_cnt - (CQ_AW+1)'(1);
            default: cq_cnt_next = cq_cnt;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETBAR) begin
        if (!RESETBAR) begin
            cq_wr_ptr <= '0;
            cq_rd_ptr <= '0;
            cq_cnt    <= '0;
            notfull_q <= 1'b1;
        end else begin
            if (cq_push) cq_wr_ptr <= cq_wr_ptr + CQ_AW'(1);
            if (issue_c) cq_rd_ptr <= cq_rd_ptr + CQ_AW'(1);
            cq_cnt    <= cq_cnt_next;
            notfull_q <= (cq_cnt_next < (CQ_AW+1)'(CQ_DEPTH));
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge CLK) begin
        if (cq_push) begin
            cq_mem[cq_wr_ptr] <= '{cmd:  CMD,
                                   sz:   SZ,
                                   rank: ADDR[HOST_ADDR_WIDTH-1 -: RANK_BITS],
                                   addr: ADDR[ADDR_WIDTH-1:0]};
        end
    end

    // Registered command broadcast with one-hot issue strobe
    always_ff @(posedge CLK or negedge RESETBAR) begin
        if (!RESETBAR) begin
            core_cmd     <= '0;
            core_sz      <= '0;
            core_addr    <= '0;
            core_cmd_put <= '0;
        end else begin
            core_cmd_put <= '0;
            if (issue_c) begin
                core_cmd     <= cq_head.cmd;
                core_sz      <= cq_head.sz;
                core_addr    <= cq_head.addr;
                core_cmd_put <= NUM_RANKS'(1) << cq_head.rank;
            end
        end
    end

    assign tag_full     = (tag_cnt == (TAG_AW+1)'(TAG_DEPTH));
    assign tag_nonempty = (tag_cnt != '0);
    assign tag_push     = issue_c && head_is_read;
    assign tag_head     = tag_mem[tag_rd_ptr];
    assign head_rank    = tag_head.rank;
    // A zero counter means the head tag has not started; take its burst length
    assign beats_left   = (beat_cnt == 4'd0) ? tag_head.beats : beat_cnt;
    assign beat_fire    = VALIDOUT && FETCHING;
    assign tag_pop      = beat_fire && (beats_left == 4'd1);

    always_comb begin
        tag_cnt_next = tag_cnt;
        case ({tag_push, tag_pop})
            2'b10:   tag_cnt_next = tag_cnt + (TAG_AW+1)'(1);
            2'b01:   tag_cnt_next = tag_cnt - (TAG_AW+1)'(1);
            default: tag_cnt_next = tag_cnt;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETBAR) begin
        if (!RESETBAR) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
            tag_cnt    <= '0;
            beat_cnt   <= '0;
        end else begin
            if (tag_push) tag_wr_ptr <= tag_wr_ptr + TAG_AW'(1);
            if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + TAG_AW'(1);
            tag_cnt <= tag_cnt_next;
            if (tag_pop)        beat_cnt <= 4'd0;
            else if (beat_fire) beat_cnt <= beats_left - 4'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (tag_push) begin
            tag_mem[tag_wr_ptr] <= '{rank:  cq_head.rank,
                                     beats: {1'b0, cq_head.sz, 1'b0} + 4'd2};
        end
    end

    // Only the head-tag rank is fetched and forwarded to the host
    assign VALIDOUT      = tag_nonempty && core_validout[head_rank];
    assign DOUT          = core_dout[head_rank*DATA_WIDTH +: DATA_WIDTH];
    assign RADDR         = {head_rank, core_raddr[head_rank*ADDR_WIDTH +: ADDR_WIDTH]};
    assign core_fetching = (FETCHING && tag_nonempty) ? (NUM_RANKS'(1) << head_rank) : '0;

    assign READY         = &core_ready;
    assign core_din      = DIN;
    assign core_put_data = put_dataFIFO ? (NUM_RANKS'(1) << ADDR[HOST_ADDR_WIDTH-1 -: RANK_BITS]) : '0;

`ifdef DDR2_RANK_STALL_CNT_EN
    // Saturating count of cycles the head entry waited on its rank
    logic [NUM_RANKS-1:0][15:0] stall_q;

    always_ff @(posedge CLK or negedge RESETBAR) begin
        if (!RESETBAR) begin
            stall_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_RANKS; r++) begin
                if (!cq_empty && !issue_c && (cq_head.rank == RANK_BITS'(r))
                    && (stall_q[r] != 16'hFFFF)) begin
                    stall_q[r] <= stall_q[r] + 16'd1;
                end
            end
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ddr2_rank_dispatcher.sv
// Scoreboard bench for ddr2_rank_dispatcher with a two-rank behavioural core model.
`timescale 1ns/1ps
module tb_ddr2_rank_dispatcher;

    logic          CLK = 1'b0;
    logic          RESETBAR;
    logic [2:0]    CMD;
    logic [1:0]    SZ;
    logic [25:0]   ADDR;
    logic          cmd_put;
    logic [63:0]   DIN;
    logic          put_dataFIFO;
    logic          FETCHING;
    logic [63:0]   DOUT;
    logic [25:0]   RADDR;
    logic          VALIDOUT, NOTFULL, READY;
    logic [2:0]    core_cmd;
    logic [1:0]    core_sz;
    logic [24:0]   core_addr;
    logic [1:0]    core_cmd_put;
    logic [63:0]   core_din;
    logic [1:0]    core_put_data, core_fetching;
    logic [1:0]    core_ready, core_notfull, core_validout;
    logic [127:0]  core_dout;
    logic [49:0]   core_raddr;
`ifdef DDR2_RANK_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    ddr2_rank_dispatcher dut (
        .CLK(CLK), .RESETBAR(RESETBAR), .CMD(CMD), .SZ(SZ), .ADDR(ADDR), .cmd_put(cmd_put),
        .DIN(DIN), .put_dataFIFO(put_dataFIFO), .FETCHING(FETCHING), .DOUT(DOUT), .RADDR(RADDR),
        .VALIDOUT(VALIDOUT), .NOTFULL(NOTFULL), .READY(READY), .core_cmd(core_cmd),
        .core_sz(core_sz), .core_addr(core_addr), .core_cmd_put(core_cmd_put),
        .core_din(core_din), .core_put_data(core_put_data), .core_fetching(core_fetching),
        .core_ready(core_ready), .core_notfull(core_notfull), .core_validout(core_validout),
        .core_dout(core_dout), .core_raddr(core_raddr)
`ifdef DDR2_RANK_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [1:0] put; logic [2:0] cmd; logic [1:0] sz; logic [24:0] addr; } iss_t;
    typedef struct { logic [63:0] dout; logic [25:0] raddr; } beat_t;
    typedef struct { int rank; logic [24:0] addr; int beats; int idx; int ready; } burst_t;

    iss_t   exp_issue[$];
    beat_t  exp_beat[$];
    burst_t rb[$];
    int     issue_cycles[$];
    int     beat_cycles[$];
    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     lat[2];
    logic [1:0] fire;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [63:0] beat_data(input int r, input logic [24:0] a, input int i);
        return {8'(r), 19'd0, a, 4'd0, 8'(i)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Host command; accept=1 queues the issue and read-return expectations
    task automatic put(input logic [2:0] c, input logic [1:0] s, input logic [25:0] a, input bit accept);
        CMD = c; SZ = s; ADDR = a; cmd_put = 1'b1;
        if (accept) begin
            exp_issue.push_back('{put: (a[25] ? 2'b10 : 2'b01), cmd: c, sz: s, addr: a[24:0]});
            if (c == 3'b001) begin
                for (int i = 0; i < 2 * (int'(s) + 1); i++)
                    exp_beat.push_back('{dout: beat_data(int'(a[25]), a[24:0], i),
                                         raddr: {a[25], a[24:0] + 25'(i)}});
            end
        end
        @(negedge CLK);
        cmd_put = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n;
        n = 0;
        while ((exp_issue.size() != 0 || exp_beat.size() != 0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, 64'(exp_issue.size() + exp_beat.size()), 64'd0);
    endtask

    // Rank model: accepts read issues and serves bursts beat by beat when fetched
    always begin
        int r;
        @(negedge CLK);
        #1;
        if (!RESETBAR) begin
            rb.delete();
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (fire[q]) begin
                    for (int k = 0; k < rb.size(); k++) begin
                        if (rb[k].rank == q) begin
                            rb[k].idx++;
                            if (rb[k].idx == rb[k].beats) rb.delete(k);
                            break;
                        end
                    end
                end
            end
            if (core_cmd_put != 2'b00 && core_cmd == 3'b001) begin
                r = core_cmd_put[1] ? 1 : 0;
                rb.push_back('{rank: r, addr: core_addr, beats: 2 * (int'(core_sz) + 1),
                               idx: 0, ready: cyc + lat[r]});
            end
        end
        core_validout = '0;
        core_dout     = '0;
        core_raddr    = '0;
        for (int q = 0; q < 2; q++) begin
            for (int k = 0; k < rb.size(); k++) begin
                if (rb[k].rank == q) begin
                    if (cyc >= rb[k].ready) begin
                        core_validout[q] = 1'b1;
                        core_dout[q*64 +: 64]  = beat_data(q, rb[k].addr, rb[k].idx);
                        core_raddr[q*25 +: 25] = rb[k].addr + 25'(rb[k].idx);
                    end
                    break;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever an issue strobe or a host beat appears
    always begin
        iss_t  ei;
        beat_t eb;
        @(negedge CLK);
        #3;
        if (RESETBAR) begin
            if (core_cmd_put != 2'b00) begin
                issue_cycles.push_back(cyc);
                if (exp_issue.size() == 0) begin
                    chk("issue_unexpected", 64'(core_cmd_put), 64'd0);
                end else begin
                    ei = exp_issue.pop_front();
                    chk("issue_put",  64'(core_cmd_put), 64'(ei.put));
                    chk("issue_cmd",  64'(core_cmd),     64'(ei.cmd));
                    chk("issue_sz",   64'(core_sz),      64'(ei.sz));
                    chk("issue_addr", 64'(core_addr),    64'(ei.addr));
                end
            end
            if (VALIDOUT && FETCHING) begin
                beat_cycles.push_back(cyc);
                if (exp_beat.size() == 0) begin
                    chk("beat_unexpected", 64'(VALIDOUT), 64'd0);
                end else begin
                    eb = exp_beat.pop_front();
                    chk("beat_dout",  DOUT,          eb.dout);
                    chk("beat_raddr", 64'(RADDR),    64'(eb.raddr));
                end
            end
            fire = core_validout & core_fetching;
        end else begin
            fire = '0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ib, bb, n;
        RESETBAR = 1'b0; cmd_put = 1'b0; CMD = '0; SZ = '0; ADDR = '0; DIN = '0;
        put_dataFIFO = 1'b0; FETCHING = 1'b0; core_ready = 2'b00; core_notfull = 2'b11;
        lat[0] = 2; lat[1] = 2;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_notfull",  64'(NOTFULL),      64'd1);
        chk("rst_validout", 64'(VALIDOUT),     64'd0);
        chk("rst_cmd_put",  64'(core_cmd_put), 64'd0);
        chk("rst_core_cmd", 64'({core_cmd, core_sz, core_addr}), 64'd0);
        @(negedge CLK);
        RESETBAR = 1'b1;
        @(negedge CLK);

        // Write-data steering is combinational
        DIN = 64'hDEAD_BEEF_0123_4567; put_dataFIFO = 1'b1; ADDR = 26'h200_0000;
        #1;
        chk("steer_rank1", 64'(core_put_data), 64'h2);
        chk("din_pass",    core_din,           64'hDEAD_BEEF_0123_4567);
        ADDR = 26'h000_0004;
        #1;
        chk("steer_rank0", 64'(core_put_data), 64'h1);
        put_dataFIFO = 1'b0;
        #1;
        chk("steer_idle",  64'(core_put_data), 64'h0);
        @(negedge CLK);

        // Fill the queue with no rank ready, drop the 9th, then drain back to back
        for (int i = 0; i < 8; i++) put(3'b010, 2'(i % 4), 26'(i * 4), 1'b1);
        #1;
        chk("full_notfull", 64'(NOTFULL), 64'd0);
        chk("ready_none",   64'(READY),   64'd0);
        @(negedge CLK);
        put(3'b010, 2'd0, 26'h3C, 1'b0);
        #1;
        chk("drop_notfull", 64'(NOTFULL), 64'd0);
        ib = issue_cycles.size();
        core_ready = 2'b01;
        #1;
        chk("ready_partial", 64'(READY), 64'd0);
        core_ready = 2'b11;
        #1;
        chk("ready_all", 64'(READY), 64'd1);
        wait_drain("drain_writes", 40);
        chk("b2b_count", 64'(issue_cycles.size() - ib), 64'd8);
        if (issue_cycles.size() - ib >= 8)
            chk("b2b_span", 64'(issue_cycles[ib+7] - issue_cycles[ib]), 64'd7);
        chk("notfull_after_drain", 64'(NOTFULL), 64'd1);

        // Rank-1 read of 4 beats with rank bit re-attached
        FETCHING = 1'b1;
        put(3'b001, 2'd1, 26'h200_0010, 1'b1);
        wait_drain("drain_read_r1", 40);
        repeat (2) @(negedge CLK);
        #4;
        chk("tag_empty_validout", 64'(VALIDOUT),      64'd0);
        chk("tag_empty_fetching", 64'(core_fetching), 64'd0);
        @(negedge CLK);

        // Out-of-order completion: rank 0 ready first but waits behind rank 1
        lat[0] = 1; lat[1] = 8;
        put(3'b001, 2'd0, 26'h200_0020, 1'b1);
        put(3'b001, 2'd0, 26'h000_0030, 1'b1);
        n = 0;
        #2;
        while (!(core_validout[0] && !core_validout[1]) && n < 30) begin
            @(negedge CLK);
            #2;
            n++;
        end
        chk("ooo_window", 64'(n < 30), 64'd1);
        chk("ooo_held",   64'(VALIDOUT), 64'd0);
        @(negedge CLK);
        wait_drain("drain_ooo", 40);
        lat[0] = 2; lat[1] = 2;

        // Tag FIFO full: the 9th read waits for the first tag pop
        FETCHING = 1'b0;
        ib = issue_cycles.size();
        bb = beat_cycles.size();
        for (int i = 0; i < 9; i++) put(3'b001, 2'd0, {1'(i % 2), 25'(25'h100 + i * 16)}, 1'b1);
        repeat (15) @(negedge CLK);
        chk("tag_full_stall", 64'(issue_cycles.size() - ib), 64'd8);
        FETCHING = 1'b1;
        n = 0;
        while (issue_cycles.size() - ib < 9 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("tag_full_release", 64'(issue_cycles.size() - ib), 64'd9);
        if (issue_cycles.size() - ib >= 9 && beat_cycles.size() - bb >= 2)
            chk("tag_pop_to_issue", 64'(issue_cycles[ib+8] - beat_cycles[bb+1]), 64'd2);
        wait_drain("drain_tagfull", 80);

        // Host back-pressure mid-burst holds data and beat count
        bb = beat_cycles.size();
        put(3'b001, 2'd1, 26'h000_0040, 1'b1);
        n = 0;
        while (beat_cycles.size() - bb < 2 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        FETCHING = 1'b0;
        chk("pause_two_beats", 64'(beat_cycles.size() - bb), 64'd2);
        for (int k = 0; k < 3; k++) begin
            #4;
            chk("pause_validout", 64'(VALIDOUT), 64'd1);
            chk("pause_dout",     DOUT,          beat_data(0, 25'h40, 2));
            chk("pause_raddr",    64'(RADDR),    64'(26'h000_0042));
            @(negedge CLK);
        end
        FETCHING = 1'b1;
        wait_drain("drain_pause", 40);

        // Reset mid-burst drops the queued command and outstanding tag
        bb = beat_cycles.size();
        put(3'b001, 2'd3, 26'h200_0050, 1'b1);
        core_ready = 2'b00;
        put(3'b010, 2'd0, 26'h000_0060, 1'b0);
        n = 0;
        while (beat_cycles.size() - bb < 3 && n < 30) begin
            @(negedge CLK);
            n++;
        end
        RESETBAR = 1'b0;
        exp_beat.delete();
        exp_issue.delete();
        #1;
        chk("midrst_validout", 64'(VALIDOUT),     64'd0);
        chk("midrst_notfull",  64'(NOTFULL),      64'd1);
        chk("midrst_cmd_put",  64'(core_cmd_put), 64'd0);
        ib = issue_cycles.size();
        repeat (2) @(negedge CLK);
        RESETBAR = 1'b1;
        core_ready = 2'b11;
        repeat (10) @(negedge CLK);
        #4;
        chk("midrst_no_issue",  64'(issue_cycles.size() - ib), 64'd0);
        chk("midrst_idle_out",  64'(VALIDOUT),      64'd0);
        chk("midrst_idle_ftch", 64'(core_fetching), 64'd0);
        @(negedge CLK);

`ifdef DDR2_RANK_STALL_CNT_EN
        core_ready = 2'b01;
        put(3'b010, 2'd0, 26'h200_0070, 1'b1);
        repeat (20) @(negedge CLK);
        core_ready = 2'b11;
        @(negedge CLK);
        #1;
        chk("stall_rank1", 64'(stall_cnt[31:16]), 64'd20);
        chk("stall_rank0", 64'(stall_cnt[15:0]),  64'd0);
        @(negedge CLK);
        wait_drain("drain_stall", 20);
`endif

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
